// File: rtl/adder_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// adder_ctrl_pkg
// Shared types and constants for the nibble-serial add/subtract controller.
//   state_t : controller states (IDLE, RUN, DONE)
//   OP_ADD  : op_sub encoding for a + b + cin
//   OP_SUB  : op_sub encoding for a - b
// ----------------------------------------------------------------------------
package adder_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/adder_4bit.sv
// ----------------------------------------------------------------------------
// adder_4bit
// Existing 4-bit ripple adder slice of the ALU datapath.
//   a, b : 4-bit addends
//   ci   : carry in
//   s    : 4-bit sum
//   co   : carry out
// ----------------------------------------------------------------------------
module adder_4bit (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       ci,
   output logic [3:0] s,
   output logic       co
);

   assign {co, s} = {1'b0, a} + {1'b0, b} + {4'b0000, ci};

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// ----------------------------------------------------------------------------
// nibble_serial_adder_ctrl
// Performs a WIDTH-bit add or subtract by sequencing one shared adder_4bit
// slice over the operands, least-significant nibble first, one nibble per
// cycle. Valid/ready handshake on both sides.
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid / in_ready : operand handshake (accepted only in IDLE)
//   op_sub, a, b, cin   : operation, operands, carry-in (cin unused for sub)
//   out_valid/out_ready : result handshake (held in DONE until taken)
//   s, co, ovf, zero    : registered result and flags
// ----------------------------------------------------------------------------
module nibble_serial_adder_ctrl
   import adder_ctrl_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             op_sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             co,
   output logic             ovf,
   output logic             zero
);

   localparam int NIB   = WIDTH / 4;
   localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   idx_q;
   logic [WIDTH-1:0]   a_q, b_q;      // b_q already holds b or ~b
   logic               carry_q;
   logic [WIDTH-1:0]   s_q;
   logic               co_q, ovf_q, zero_q;

   logic [3:0]         slice_a, slice_b, slice_s;
   logic               slice_co;
   logic               last_nib;
   logic [WIDTH-1:0]   s_final;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         // NOTE: every clocked register uses non-blocking assignment so all
         // flops update together from pre-edge values.
         state_q <= state_d;
      end
   end

   always_comb begin
      // NOTE: default first so no path through the case leaves state_d
      // unassigned, which would infer a latch.
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (in_valid)  state_d = RUN;
         RUN:     if (last_nib)  state_d = DONE;
         DONE:    if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);

   // ---------------------------------------------------------- slice mux
   assign last_nib = (idx_q == LAST_IDX);
   assign slice_a  = a_q[{idx_q, 2'b00} +: 4];
   assign slice_b  = b_q[{idx_q, 2'b00} +: 4];

   adder_4bit u_slice (
      .a  (slice_a),
      .b  (slice_b),
      .ci (carry_q),
      .s  (slice_s),
      .co (slice_co)
   );

   // On the last nibble the lower nibbles of s_q are already final, so the
   // complete result is the slice output on top of them. Flags derive from it.
   generate
      if (WIDTH > 4) begin : g_final_wide
         assign s_final = {slice_s, s_q[WIDTH-5:0]};
      end else begin : g_final_narrow
         assign s_final = slice_s;
      end
   endgenerate

   // ------------------------------------------------------ operand latch
   // NOTE: operand registers are pure data, only meaningful after an accept,
   // so they carry no reset and stay plain enable flops.
   always_ff @(posedge clk) begin
      if (state_q == IDLE && in_valid) begin
         a_q <= a;
         b_q <= (op_sub == OP_SUB) ? ~b : b;
      end
   end

   // ------------------------------------------------- datapath / results
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         idx_q   <= '0;
         carry_q <= 1'b0;
         s_q     <= '0;
         co_q    <= 1'b0;
         ovf_q   <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (in_valid) begin
                  idx_q   <= '0;
                  carry_q <= (op_sub == OP_SUB) ? 1'b1 : cin;
               end
            end
            RUN: begin
               s_q[{idx_q, 2'b00} +: 4] <= slice_s;
               carry_q                  <= slice_co;
               idx_q                    <= idx_q + 1'b1;
               if (last_nib) begin
                  co_q   <= slice_co;
                  ovf_q  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                            (s_final[WIDTH-1] != a_q[WIDTH-1]);
                  zero_q <= ~|s_final;
               end
            end
            default: ;  // DONE: results held
         endcase
      end
   end

   assign s    = s_q;
   assign co   = co_q;
   assign ovf  = ovf_q;
   assign zero = zero_q;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// ----------------------------------------------------------------------------
// tb_nibble_serial_adder_ctrl
// Directed, table-driven bench for nibble_serial_adder_ctrl (WIDTH=32),
// plus hand sequences for backpressure and mid-operation reset.
// ----------------------------------------------------------------------------
module tb_nibble_serial_adder_ctrl;
   import adder_ctrl_pkg::*;

   localparam int WIDTH   = 32;
   localparam int LAT     = 8;
   localparam int MAX_LAT = 20;
   localparam int NVEC    = 10;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              in_valid;
   logic              in_ready;
   logic              op_sub;
   logic [WIDTH-1:0]  a, b;
   logic              cin;
   logic              out_valid;
   logic              out_ready;
   logic [WIDTH-1:0]  s;
   logic              co, ovf, zero;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic        op;
      logic [31:0] a;
      logic [31:0] b;
      logic        cin;
      logic [31:0] s;
      logic        co;
      logic        ovf;
      logic        zero;
   } vec_t;

   vec_t vecs [NVEC];

   always #5 clk = ~clk;

   nibble_serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op_sub    (op_sub),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .s         (s),
      .co        (co),
      .ovf       (ovf),
      .zero      (zero)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Present operands at a negedge, accept on the next posedge, then scramble
   // the operand inputs so a late sample would corrupt the result.
   task automatic start_op(input string tag, input logic op, input logic [31:0] va,
                           input logic [31:0] vb, input logic vcin);
      @(negedge clk);
      check({tag, " in_ready before accept"}, 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      op_sub   = op;
      a        = va;
      b        = vb;
      cin      = vcin;
      @(negedge clk);
      in_valid = 1'b0;
      op_sub   = ~op;
      a        = $urandom;
      b        = $urandom;
      cin      = ~vcin;
      check({tag, " in_ready after accept"}, 32'(in_ready), 32'd0);
      check({tag, " out_valid after accept"}, 32'(out_valid), 32'd0);
   endtask

   // Called at the negedge right after the accept edge; counts edges until
   // out_valid is seen, bounded by MAX_LAT.
   task automatic wait_done(output int lat);
      lat = 0;
      while (!out_valid && lat < MAX_LAT) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic check_result(input string tag, input vec_t v, input int lat);
      check({tag, " latency"}, 32'(lat), 32'(LAT));
      check({tag, " s"},    s,         v.s);
      check({tag, " co"},   32'(co),   32'(v.co));
      check({tag, " ovf"},  32'(ovf),  32'(v.ovf));
      check({tag, " zero"}, 32'(zero), 32'(v.zero));
   endtask

   task automatic finish_op(input string tag);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, " in_ready after take"},  32'(in_ready),  32'd1);
      check({tag, " out_valid after take"}, 32'(out_valid), 32'd0);
   endtask

   initial begin
      int   lat;
      vec_t v;

      //          op      a             b             cin   s             co    ovf   zero
      vecs[0] = '{OP_ADD, 32'h0000000F, 32'h00000001, 1'b0, 32'h00000010, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{OP_ADD, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
      vecs[2] = '{OP_SUB, 32'h00000005, 32'h00000007, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
      vecs[3] = '{OP_SUB, 32'h80000000, 32'h00000001, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
      vecs[4] = '{OP_ADD, 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
      vecs[5] = '{OP_ADD, 32'h00000000, 32'h00000000, 1'b1, 32'h00000001, 1'b0, 1'b0, 1'b0};
      vecs[6] = '{OP_SUB, 32'h00000010, 32'h00000010, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
      vecs[7] = '{OP_ADD, 32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0, 1'b0, 1'b0};
      vecs[8] = '{OP_ADD, 32'h0000FFFF, 32'h00000000, 1'b1, 32'h00010000, 1'b0, 1'b0, 1'b0};
      vecs[9] = '{OP_ADD, 32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1};

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      op_sub    = OP_ADD;
      a         = '0;
      b         = '0;
      cin       = 1'b0;
      out_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Reset state
      check("rst in_ready",  32'(in_ready),  32'd1);
      check("rst out_valid", 32'(out_valid), 32'd0);
      check("rst s",         s,              32'h0);
      check("rst co",        32'(co),        32'd0);
      check("rst ovf",       32'(ovf),       32'd0);
      check("rst zero",      32'(zero),      32'd0);

      // Table-driven vectors
      for (int i = 0; i < NVEC; i++) begin
         string tag;
         tag = $sformatf("vec%0d", i);
         v   = vecs[i];
         start_op(tag, v.op, v.a, v.b, v.cin);
         wait_done(lat);
         check_result(tag, v, lat);
         finish_op(tag);
      end

      // Backpressure: result held for 5 cycles while new operands are offered
      v = '{OP_ADD, 32'hA5A5A5A5, 32'h01010101, 1'b0, 32'hA6A6A6A6, 1'b0, 1'b0, 1'b0};
      start_op("bp", v.op, v.a, v.b, v.cin);
      wait_done(lat);
      check_result("bp", v, lat);
      for (int c = 0; c < 5; c++) begin
         in_valid = 1'b1;
         op_sub   = OP_SUB;
         a        = $urandom;
         b        = $urandom;
         @(negedge clk);
         check($sformatf("bp hold%0d out_valid", c), 32'(out_valid), 32'd1);
         check($sformatf("bp hold%0d in_ready", c),  32'(in_ready),  32'd0);
         check($sformatf("bp hold%0d s", c),         s,              v.s);
         check($sformatf("bp hold%0d flags", c),     {29'd0, co, ovf, zero}, 32'd0);
      end
      in_valid = 1'b0;
      finish_op("bp");
      repeat (LAT + 3) @(negedge clk);
      check("bp nothing queued out_valid", 32'(out_valid), 32'd0);
      check("bp nothing queued in_ready",  32'(in_ready),  32'd1);

      // Reset while idx=3 of a RUN
      start_op("mid_rst", OP_ADD, 32'hFFFFFFFF, 32'h00000001, 1'b0);
      repeat (3) @(negedge clk);
      check("mid_rst still running", 32'(in_ready), 32'd0);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("mid_rst in_ready",  32'(in_ready),  32'd1);
      check("mid_rst out_valid", 32'(out_valid), 32'd0);
      check("mid_rst s",         s,              32'h0);
      check("mid_rst flags",     {29'd0, co, ovf, zero}, 32'd0);
      repeat (LAT + 2) @(negedge clk);
      check("mid_rst discarded", 32'(out_valid), 32'd0);
      v = '{OP_ADD, 32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0, 1'b0, 1'b0};
      start_op("post_rst", v.op, v.a, v.b, v.cin);
      wait_done(lat);
      check_result("post_rst", v, lat);
      finish_op("post_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/nibble_serial_adder_ctrl.md
Name: nibble_serial_adder_ctrl

Overview:
Sequencer that time-shares one adder_4bit slice to perform WIDTH-bit add/subtract, one nibble per cycle, least-significant nibble first.
Sits between the MIPS ALU issue logic and the existing 4-bit adder datapath.
Uses a valid/ready handshake on both input and output.
Trades latency (WIDTH/4 cycles) for area.

Parameters:
WIDTH, 32, operand/result width; must be a multiple of 4 and >= 8
NIB, WIDTH/4, nibble count (derived, localparam)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset; one clock; reset is synchronous and active-low
in_valid  in  1  operands presented
in_ready  out  1  controller can accept operands
op_sub  in  1  0 = a+b+cin, 1 = a-b (b inverted, cin forced 1)
a  in  WIDTH  operand A
b  in  WIDTH  operand B
cin  in  1  carry-in for add; ignored when op_sub=1
out_valid  out  1  result available
out_ready  in  1  consumer takes result
s  out  WIDTH  sum/difference
co  out  1  carry out of MSB (sub: 1 = no borrow)
ovf  out  1  signed overflow
zero  out  1  s == 0

Behaviour:
- States: IDLE, RUN, DONE.
- Reset (rst_n low at clk edge) forces: state=IDLE, in_ready=1, out_valid=0, s=0, co=0, ovf=0, zero=0, nibble index=0. This applies in any state, including mid-RUN; any in-flight operation is discarded.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, latch a and b_eff=(op_sub ? ~b : b), and carry_reg=(op_sub ? 1 : cin).
  - Set idx=0 and go to RUN.
- RUN:
  - in_ready=0, out_valid=0.
  - Each cycle feeds the adder slice with a[idx*4+:4], b_eff[idx*4+:4], carry_reg.
  - Writes the slice sum into s[idx*4+:4] and the slice co into carry_reg; idx increments.
  - When idx==NIB-1 the cycle's write completes the result. Go to DONE.
- DONE:
  - out_valid=1; s, co (=final carry_reg), ovf and zero are held stable.
  - Go to IDLE on out_ready.
  - in_ready=0 in DONE; a new operation can be accepted no earlier than the cycle after the handshake.
- Latency: out_valid rises exactly NIB cycles after the accepting edge (8 for WIDTH=32).
  - Minimum throughput: one operation per NIB+2 cycles.
- ovf = (a[MSB] == b_eff[MSB]) && (s[MSB] != a[MSB]), evaluated on the final result.
- zero = ~|s.
- Outputs s/co/ovf/zero are registered. Their values outside DONE are don't-care, but they must not change while out_valid=1.
- in_valid while not in IDLE is ignored (no queuing). Operand inputs are sampled only at the accept edge; later changes have no effect.
- Carry chains across nibbles purely through carry_reg. Wrap-around: the final carry is reported on co, never fed back.
- out_ready asserted outside DONE has no effect.

Decomposition:
- Package adder_ctrl_pkg holds the state enum (IDLE, RUN, DONE) and constants OP_ADD=1'b0 and OP_SUB=1'b1.
- One sub-module: the existing adder_4bit, instantiated once as the shared slice (ports a, b, ci, s, co).
- Nibble muxing, the state machine and flag logic live in the controller.

Test Plan:
- Add 0x0000000F + 0x00000001, cin=0 -> s=0x00000010, co=0, ovf=0, zero=0; out_valid exactly 8 cycles after accept.
- Add 0xFFFFFFFF + 0x00000001 -> s=0x00000000, co=1, zero=1, ovf=0. This exercises carry propagation through all 8 nibbles.
- Sub 0x00000005 - 0x00000007 -> s=0xFFFFFFFE, co=0 (borrow), ovf=0. Sub 0x80000000 - 0x00000001 -> s=0x7FFFFFFF, co=1, ovf=1.
- Add 0x7FFFFFFF + 0x00000001 -> s=0x80000000, ovf=1, co=0. Add 0x00000000 + 0x00000000, cin=1 -> s=0x00000001.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while pulsing in_valid with new operands -> s/flags stable, in_ready=0, new operands not taken. Release out_ready -> IDLE next cycle, in_ready=1.
- Assert rst_n=0 for one edge at idx=3 of a RUN -> next cycle state IDLE, out_valid=0, in_ready=1, all outputs 0. A following add 0x12345678 + 0x11111111 -> s=0x23456789.
